// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle datapath.
// Runs a two-byte fetch (F1..F4), dispatches on the opcode captured in F4,
// then steps through the load, store, jump/branch or ALU micro-sequence.
// Outputs are decoded from the state register. The one exception is PCldEn
// in the jump/branch state, which follows the live branch condition.
// Optional build macro MC_HALT_EN adds a HLT state for opcode 1111 and
// drives the halted flag. Without it, 1111 is a NOP and halted stays 0.
module multicycle_controller #(
    parameter int OPCODE_W = 4,
    parameter int FLAG_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAG_W-1:0]   FlagOut,
    input  logic [1:0]          JmpSel,
    output logic                PCsrc,
    output logic                PCldEn,
    output logic                PCout,
    output logic                IRldR,
    output logic                IRldL,
    output logic                RegSel,
    output logic                IRDout,
    output logic                IRAout,
    output logic                Mout,
    output logic                Mld,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                RegFileSel,
    output logic                Rout,
    output logic                Rld,
    output logic                DIld,
    output logic                Ald,
    output logic                Bld,
    output logic                ALUResOut,
    output logic                ALUResld,
    output logic                CZNld,
    output logic [1:0]          ALUOp,
    output logic [3:0]          state_o,
    output logic                halted
);

    // JMP and BRC share one state. The opcode captured in F4 decides
    // whether the PC load is unconditional or follows the branch condition.
    localparam logic [3:0] ST_F1  = 4'd0;
    localparam logic [3:0] ST_F2  = 4'd1;
    localparam logic [3:0] ST_F3  = 4'd2;
    localparam logic [3:0] ST_F4  = 4'd3;
    localparam logic [3:0] ST_L1  = 4'd4;
    localparam logic [3:0] ST_L2  = 4'd5;
    localparam logic [3:0] ST_S1  = 4'd6;
    localparam logic [3:0] ST_S2  = 4'd7;
    localparam logic [3:0] ST_JB  = 4'd8;
    localparam logic [3:0] ST_A1  = 4'd9;
    localparam logic [3:0] ST_A2  = 4'd10;
    localparam logic [3:0] ST_A3  = 4'd11;
    localparam logic [3:0] ST_A4  = 4'd12;
    localparam logic [3:0] ST_A5  = 4'd13;
    localparam logic [3:0] ST_A6  = 4'd14;
`ifdef MC_HALT_EN
    localparam logic [3:0] ST_HLT = 4'd15;
`endif

    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0010;

    logic [3:0]          state;
    logic [3:0]          next_state;
    logic [OPCODE_W-1:0] op_q;
    logic                cond;

    assign state_o = state;

    // State register. Reset always returns to F1 (code 0), whatever state the FSM is in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_F1;
        end else begin
            state <= next_state;
        end
    end

    // Hold the opcode seen in F4 so that later IR changes cannot affect the instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
        end else if (state == ST_F4) begin
            op_q <= opcode;
        end
    end

    // Branch condition from JmpSel against the flags {C,Z,N} as they are in this cycle.
    always_comb begin
        cond = 1'b1;
        case (JmpSel)
            2'b00:   cond = 1'b1;
            2'b01:   cond = FlagOut[2];
            2'b10:   cond = FlagOut[1];
            default: cond = FlagOut[0];
        endcase
    end

    // Next-state logic: fixed fetch sequence, decode dispatch in F4, micro-steps back to F1.
    always_comb begin
        next_state = ST_F1;
        case (state)
            ST_F1: next_state = ST_F2;
            ST_F2: next_state = ST_F3;
            ST_F3: next_state = ST_F4;
            ST_F4: begin
                casez (opcode)
                    4'b0000: next_state = ST_L1;
                    4'b0001: next_state = ST_S1;
                    4'b001?: next_state = ST_JB;
                    4'b01??: next_state = ST_A1;
`ifdef MC_HALT_EN
                    4'b1111: next_state = ST_HLT;
`endif
                    default: next_state = ST_F1;
                endcase
            end
            ST_L1: next_state = ST_L2;
            ST_S1: next_state = ST_S2;
            ST_A1: next_state = ST_A2;
            ST_A2: next_state = ST_A3;
            ST_A3: next_state = ST_A4;
            ST_A4: next_state = ST_A5;
            ST_A5: next_state = ST_A6;
`ifdef MC_HALT_EN
            ST_HLT: next_state = ST_HLT;
`endif
            default: next_state = ST_F1;
        endcase
    end

    // Strobe decode. Reset masks everything so that no write can escape mid-instruction.
    always_comb begin
        PCsrc      = 1'b0;
        PCldEn     = 1'b0;
        PCout      = 1'b0;
        IRldR      = 1'b0;
        IRldL      = 1'b0;
        RegSel     = 1'b0;
        IRDout     = 1'b0;
        IRAout     = 1'b0;
        Mout       = 1'b0;
        Mld        = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegFileSel = 1'b0;
        Rout       = 1'b0;
        Rld        = 1'b0;
        DIld       = 1'b0;
        Ald        = 1'b0;
        Bld        = 1'b0;
        ALUResOut  = 1'b0;
        ALUResld   = 1'b0;
        CZNld      = 1'b0;
        ALUOp      = 2'b00;
        halted     = 1'b0;
        if (!rst) begin
            case (state)
                ST_F1, ST_F3: begin
                    PCout  = 1'b1;
                    Mld    = 1'b1;
                    PCldEn = 1'b1;
                end
                ST_F2: begin
                    Mout  = 1'b1;
                    IRldL = 1'b1;
                end
                ST_F4: begin
                    Mout  = 1'b1;
                    IRldR = 1'b1;
                    DIld  = 1'b1;
                end
                ST_L1: begin
                    IRAout = 1'b1;
                    Mld    = 1'b1;
                end
                ST_L2: begin
                    Mout       = 1'b1;
                    RegWrite   = 1'b1;
                    RegFileSel = 1'b1;
                    RegSel     = 1'b1;
                end
                ST_S1: begin
                    RegFileSel = 1'b1;
                    Rld        = 1'b1;
                end
                ST_S2: begin
                    Rout     = 1'b1;
                    IRAout   = 1'b1;
                    MemWrite = 1'b1;
                end
                ST_JB: begin
                    IRAout = 1'b1;
                    PCsrc  = 1'b1;
                    PCldEn = (op_q == OP_JMP) ? 1'b1 : cond;
                end
                ST_A1: begin
                    RegFileSel = 1'b1;
                    RegSel     = 1'b1;
                    Rld        = 1'b1;
                end
                ST_A2: begin
                    Rout = 1'b1;
                    Ald  = 1'b1;
                end
                ST_A3: begin
                    RegFileSel = 1'b1;
                    Rld        = 1'b1;
                end
                ST_A4: begin
                    Rout = 1'b1;
                    Bld  = 1'b1;
                end
                ST_A5: begin
                    ALUOp    = op_q[1:0];
                    ALUResld = 1'b1;
                    CZNld    = 1'b1;
                end
                ST_A6: begin
                    ALUResOut  = 1'b1;
                    RegWrite   = 1'b1;
                    RegFileSel = 1'b1;
                    RegSel     = 1'b1;
                end
`ifdef MC_HALT_EN
                ST_HLT: halted = 1'b1;
`endif
                default: begin
                    PCldEn = 1'b0;
                end
            endcase
        end
    end

endmodule
